bus_cycle_arbiter: RTL and testbench

BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_cycle_arbiter_if.sv | 34 +++
 rtl/arb_priority_picker.sv | 19 +
 rtl/bus_cycle_arbiter.sv | 104 ++++++++++
 tb/tb_bus_cycle_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the bus cycle arbiter.
package bus_arb_pkg;

  localparam int unsigned AddrWidthDefault = 19;
  localparam int unsigned DataWidthDefault = 8;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StT1   = 5'b00010,
    StT2   = 5'b00100,
    StT3   = 5'b01000,
    StT4   = 5'b10000
  } bus_state_e;

endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// Requester handshake plus memory/IO bus control and address signals of the arbiter.
// The shared DATA bus is tri-state and stays a plain inout port on the arbiter.
interface bus_cycle_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned DATA_WIDTH = DataWidthDefault
) ();

  logic [1:0]            REQ;
  logic [1:0]            WRITE_N;
  logic [ADDR_WIDTH-1:0] ADDR0;
  logic [ADDR_WIDTH-1:0] ADDR1;
  logic [DATA_WIDTH-1:0] WDATA0;
  logic [DATA_WIDTH-1:0] WDATA1;
  logic [1:0]            ACK;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  ALE;
  logic                  CS;
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  modport master (
    input  REQ, WRITE_N, ADDR0, ADDR1, WDATA0, WDATA1,
    output ACK, RDATA, ALE, CS, RD, WR, ADDRESS
  );

  modport slave (
    output REQ, WRITE_N, ADDR0, ADDR1, WDATA0, WDATA1,
    input  ACK, RDATA, ALE, CS, RD, WR, ADDRESS
  );

endinterface

// File: rtl/arb_priority_picker.sv
// Combinational winner select between the CPU (0) and DMA (1) requesters.
// prio_i names the requester that wins when both request at once.
module arb_priority_picker (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = prio_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Two-requester arbiter running 4-clock T1..T4 memory/IO bus cycles.
// Define ARB_ROUND_ROBIN_EN for alternating grants; otherwise requester 0 has fixed priority.
module bus_cycle_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDefault,
  parameter int unsigned DATA_WIDTH = DataWidthDefault
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_cycle_arbiter_if.master   bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  bus_state_e            state_q, state_d;
  logic                  grant;
  logic                  pick;
  logic                  prio;
  logic                  winner_q;
  logic                  write_n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  strobe;
  logic                  data_oe;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;

  // Pointer names the requester not granted last; reset favours requester 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q <= 1'b0;
    end else if (grant) begin
      ptr_q <= ~pick;
    end
  end

  assign prio = ptr_q;
`else
  assign prio = 1'b0;
`endif

  arb_priority_picker u_picker (
    .req_i    (bus.REQ),
    .prio_i   (prio),
    .winner_o (pick)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ != 2'b00) begin
          grant   = 1'b1;
          state_d = StT1;
        end
      end
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    state_d = StT4;
      StT4:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      winner_q  <= 1'b0;
      write_n_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        winner_q  <= pick;
        write_n_q <= bus.WRITE_N[pick];
        addr_q    <= pick ? bus.ADDR1 : bus.ADDR0;
        wdata_q   <= pick ? bus.WDATA1 : bus.WDATA0;
      end
      if (state_q == StT3 && write_n_q) begin
        rdata_q <= DATA;
      end
    end
  end

  assign strobe  = (state_q == StT2) || (state_q == StT3);
  assign data_oe = strobe && !write_n_q;

  assign bus.ALE     = (state_q == StT1);
  assign bus.CS      = (state_q == StT1) || strobe;
  assign bus.RD      = !(strobe && write_n_q);
  assign bus.WR      = !data_oe;
  assign bus.ADDRESS = bus.CS ? addr_q : '0;
  assign bus.ACK     = (state_q == StT4) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.RDATA   = rdata_q;

  // Write data only goes on the bus while the write strobe is low.
  assign DATA = data_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Directed self-checking bench for bus_cycle_arbiter with a small byte memory on the bus.
`timescale 1ns/1ps
module tb_bus_cycle_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          preload;
  wire  [DW-1:0] DATA;
  logic [DW-1:0] mem [256];
  int            n_checks = 0;
  int            n_fail = 0;

  bus_cycle_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_cycle_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .DATA  (DATA)
  );

  always #5 CLK = ~CLK;

  // Memory drives read data while RD is low and stores on each low-WR clock outside reset.
  assign DATA = (!bus.RD) ? mem[bus.ADDRESS[7:0]] : 8'hzz;

  always @(negedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hA5;
      mem[8'h20] <= 8'h5A;
    end else if (!bus.WR && !RESET) begin
      mem[bus.ADDRESS[7:0]] <= DATA;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input string tag, input int who, input logic rd,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd);
    int            lat = 0;
    int            wr_lo = 0;
    int            rd_lo = 0;
    logic [AW-1:0] ale_addr = '0;
    logic [AW-1:0] addr_ack = '1;
    logic [DW-1:0] wr_seen = '0;
    logic [DW-1:0] rd_seen = '0;
    logic [1:0]    ack = '0;
    logic          cs_ack = 1'b1;
    @(posedge CLK); #1;
    bus.WRITE_N[who] = rd;
    if (who == 0) begin
      bus.ADDR0  = addr;
      bus.WDATA0 = wd;
    end else begin
      bus.ADDR1  = addr;
      bus.WDATA1 = wd;
    end
    bus.REQ[who] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (bus.ALE) ale_addr = bus.ADDRESS;
      if (!bus.WR) begin
        wr_lo++;
        wr_seen = DATA;
      end
      if (!bus.RD) rd_lo++;
      if (bus.ACK != 2'b00) begin
        lat      = n;
        ack      = bus.ACK;
        addr_ack = bus.ADDRESS;
        cs_ack   = bus.CS;
        rd_seen  = bus.RDATA;
        break;
      end
    end
    bus.REQ[who] = 1'b0;
    check_eq({tag, "_lat"}, lat, 5);
    check_eq({tag, "_ack"}, 32'(ack), (who == 0) ? 32'h1 : 32'h2);
    check_eq({tag, "_ale_addr"}, 32'(ale_addr), 32'(addr));
    check_eq({tag, "_t4_addr"}, 32'(addr_ack), 32'h0);
    check_eq({tag, "_t4_cs"}, 32'(cs_ack), 32'h0);
    check_eq({tag, "_wr_low"}, wr_lo, rd ? 0 : 2);
    check_eq({tag, "_rd_low"}, rd_lo, rd ? 2 : 0);
    if (rd) check_eq({tag, "_rdata"}, 32'(rd_seen), 32'(exp_rd));
    else    check_eq({tag, "_wdata"}, 32'(wr_seen), 32'(wd));
  endtask

  initial begin
    int            k;
    int            last_n;
    int            first_n;
    int            second_n;
    logic [1:0]    exp_ack;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;

    RESET       = 1'b1;
    preload     = 1'b1;
    bus.REQ     = 2'b00;
    bus.WRITE_N = 2'b11;
    bus.ADDR0   = '0;
    bus.ADDR1   = '0;
    bus.WDATA0  = '0;
    bus.WDATA1  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_ack", 32'(bus.ACK), 32'h0);
    check_eq("rst_ale", 32'(bus.ALE), 32'h0);
    check_eq("rst_cs", 32'(bus.CS), 32'h0);
    check_eq("rst_rd", 32'(bus.RD), 32'h1);
    check_eq("rst_wr", 32'(bus.WR), 32'h1);
    check_eq("rst_address", 32'(bus.ADDRESS), 32'h0);
    check_eq("rst_rdata", 32'(bus.RDATA), 32'h0);
    @(posedge CLK); #1;
    RESET   = 1'b0;
    preload = 1'b0;

    // Single read, write then read-back of the top address.
    do_txn("rd0", 0, 1'b1, 19'h00010, 8'h00, 8'hA5);
    do_txn("wr1", 1, 1'b0, 19'h7FFFF, 8'h3C, 8'h00);
    check_eq("rdata_hold", 32'(bus.RDATA), 32'hA5);
    check_eq("mem_wr1", 32'(mem[8'hFF]), 32'h3C);
    do_txn("rd1", 1, 1'b1, 19'h7FFFF, 8'h00, 8'h3C);

    // Both requesting for four transactions.
    @(posedge CLK); #1;
    bus.WRITE_N = 2'b11;
    bus.ADDR0   = 19'h00010;
    bus.ADDR1   = 19'h00020;
    bus.REQ     = 2'b11;
    k = 0;
    last_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (bus.ACK != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
        exp_ack = 2'b01;
`endif
        check_eq($sformatf("both_ack%0d", k), 32'(bus.ACK), 32'(exp_ack));
        check_eq($sformatf("both_gap%0d", k), n - last_n, 5);
        check_eq($sformatf("both_rdata%0d", k), 32'(bus.RDATA),
                 (exp_ack == 2'b01) ? 32'hA5 : 32'h5A);
        last_n = n;
        k++;
        if (k == 4) begin
          bus.REQ = 2'b00;
          break;
        end
      end
    end
    bus.REQ = 2'b00;
    check_eq("both_count", k, 4);

    // Reset in T2 of a write of 8'hFF to 19'h00020.
    @(posedge CLK); #1;
    bus.WRITE_N = 2'b10;
    bus.ADDR0   = 19'h00020;
    bus.WDATA0  = 8'hFF;
    bus.REQ     = 2'b01;
    @(posedge CLK); #1;
    check_eq("abort_t1_ale", 32'(bus.ALE), 32'h1);
    @(posedge CLK); #1;
    check_eq("abort_t2_wr", 32'(bus.WR), 32'h0);
    check_eq("abort_t2_data", 32'(DATA), 32'hFF);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_eq("abort_ack", 32'(bus.ACK), 32'h0);
    check_eq("abort_ale", 32'(bus.ALE), 32'h0);
    check_eq("abort_cs", 32'(bus.CS), 32'h0);
    check_eq("abort_rd", 32'(bus.RD), 32'h1);
    check_eq("abort_wr", 32'(bus.WR), 32'h1);
    check_eq("abort_address", 32'(bus.ADDRESS), 32'h0);
    check_eq("abort_rdata", 32'(bus.RDATA), 32'h0);
    RESET       = 1'b0;
    bus.REQ     = 2'b00;
    bus.WRITE_N = 2'b11;
    do_txn("abort_rd", 0, 1'b1, 19'h00020, 8'h00, 8'h5A);

    // Requester 1 rises during T2 of a requester 0 read.
    @(posedge CLK); #1;
    bus.WRITE_N = 2'b11;
    bus.ADDR0   = 19'h00010;
    bus.ADDR1   = 19'h00020;
    bus.REQ     = 2'b01;
    first_n  = 0;
    second_n = 0;
    rd0 = '0;
    rd1 = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 3) begin
        check_eq("late_t2_rd", 32'(bus.RD), 32'h0);
        bus.REQ[1] = 1'b1;
      end
      if (bus.ACK == 2'b01 && first_n == 0) begin
        first_n    = n;
        rd0        = bus.RDATA;
        bus.REQ[0] = 1'b0;
      end
      if (bus.ACK == 2'b10) begin
        second_n   = n;
        rd1        = bus.RDATA;
        bus.REQ[1] = 1'b0;
        break;
      end
    end
    bus.REQ = 2'b00;
    check_eq("late_first_n", first_n, 5);
    check_eq("late_first_rdata", 32'(rd0), 32'hA5);
    check_eq("late_second_n", second_n, 10);
    check_eq("late_second_rdata", 32'(rd1), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
